// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one sram-like master port between the CPU
// instruction and data requesters. One transaction is outstanding at a time.
// The data side has priority over instruction fetch.
//
// Optional feature macro: ARB_FAIRNESS_EN
//   When defined, a 4-bit starvation counter forces an instruction grant
//   after STARVE_LIMIT consecutive data grants with inst_req pending.
//   When undefined, data_req always wins in IDLE.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no transaction; grant computed combinationally, addr_ok to winner
// REQ    | latched request presented downstream, waiting for m_addr_ok
// WAIT   | request accepted downstream, waiting for m_data_ok to route back

module sram_like_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk_i,
    input  logic        resetn_i,

    input  logic        inst_req_i,
    input  logic        inst_wr_i,
    input  logic [1:0]  inst_size_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] inst_wdata_i,
    output logic [31:0] inst_rdata_o,
    output logic        inst_addr_ok_o,
    output logic        inst_data_ok_o,

    input  logic        data_req_i,
    input  logic        data_wr_i,
    input  logic [1:0]  data_size_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_addr_ok_o,
    output logic        data_data_ok_o,

    output logic        m_req_o,
    output logic        m_wr_o,
    output logic [1:0]  m_size_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    input  logic [31:0] m_rdata_i,
    input  logic        m_addr_ok_i,
    input  logic        m_data_ok_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // The counter is 4 bits wide, so the limit must fit in 1..15.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_range
        $error("sram_like_arbiter: STARVE_LIMIT must be in 1..15");
    end

    state_t      state_q, state_d;
    logic        own_q,   own_d;      // 0 = inst, 1 = data
    logic        wr_q,    wr_d;
    logic [1:0]  size_q,  size_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        in_idle;
    logic        forced;
    logic        grant_data;
    logic        grant_inst;

    assign in_idle = (state_q == ST_IDLE);

`ifdef ARB_FAIRNESS_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;

    assign forced = inst_req_i && (starve_cnt_q == LIMIT);

    // Count data grants that overtake a pending fetch; clear once inst wins
    // or stops asking. Counter only moves in IDLE, where grants happen.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (in_idle) begin
            if (grant_data && inst_req_i) begin
                if (starve_cnt_q != LIMIT) begin
                    starve_cnt_d = starve_cnt_q + 4'd1;
                end
            end else if (grant_inst || !inst_req_i) begin
                starve_cnt_d = 4'd0;
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign forced = 1'b0;
`endif

    // Grants only exist in IDLE; a winner always has its req high, so the
    // grant itself is the upstream handshake.
    assign grant_data = in_idle && data_req_i && !forced;
    assign grant_inst = in_idle && inst_req_i && !grant_data;

    assign inst_addr_ok_o = grant_inst;
    assign data_addr_ok_o = grant_data;

    // Downstream fields come straight from the hold registers; wdata is not
    // masked here, strobes are generated further down the bridge.
    assign m_wr_o    = wr_q;
    assign m_size_o  = size_q;
    assign m_addr_o  = addr_q;
    assign m_wdata_o = wdata_q;

    // Read data fans out to both sides; only the owner's data_ok qualifies it.
    assign inst_rdata_o = m_rdata_i;
    assign data_rdata_o = m_rdata_i;

    // Next-state, latching of the winning request and response routing.
    always_comb begin
        state_d        = state_q;
        own_d          = own_q;
        wr_d           = wr_q;
        size_d         = size_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        m_req_o        = 1'b0;
        inst_data_ok_o = 1'b0;
        data_data_ok_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_data) begin
                    own_d   = 1'b1;
                    wr_d    = data_wr_i;
                    size_d  = data_size_i;
                    addr_d  = data_addr_i;
                    wdata_d = data_wdata_i;
                    state_d = ST_REQ;
                end else if (grant_inst) begin
                    own_d   = 1'b0;
                    wr_d    = inst_wr_i;
                    size_d  = inst_size_i;
                    addr_d  = inst_addr_i;
                    wdata_d = inst_wdata_i;
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                m_req_o = 1'b1;
                if (m_addr_ok_i) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (m_data_ok_i) begin
                    if (own_q) begin
                        data_data_ok_o = 1'b1;
                    end else begin
                        inst_data_ok_o = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, owner and hold registers.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= ST_IDLE;
            own_q   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Two-to-one arbiter that shares a single sram-like master port between the CPU instruction and data sram-like requesters, in front of the sram-like-to-AXI bridge. It latches the winning request and drives it downstream. It keeps exactly one transaction outstanding and routes the response back to its owner. Data side has priority; an optional starvation counter guarantees forward progress for instruction fetch.

## Interface
- STARVE_LIMIT, 8: consecutive data grants tolerated while inst_req is pending before inst is forced (range 1..15; counter is 4 bits).
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- inst_req / inst_wr  in  1 / 1  instruction request, write flag
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr / inst_wdata  in  32 / 32  address, write data
- inst_rdata  out  32  read data (valid with inst_data_ok)
- inst_addr_ok / inst_data_ok  out  1 / 1  request accepted / response done
- data_req, data_wr, data_size, data_addr, data_wdata, data_rdata, data_addr_ok, data_data_ok: same widths and meaning for the data side
- m_req / m_wr  out  1 / 1  downstream request, write flag
- m_size  out  2  downstream size
- m_addr / m_wdata  out  32 / 32  downstream address, write data
- m_rdata  in  32  downstream read data
- m_addr_ok / m_data_ok  in  1 / 1  downstream accept / response

## Operation
- FSM states: IDLE, REQ, WAIT; owner register own (0=inst, 1=data); hold registers for wr, size, addr, wdata.
- IDLE: grant computed combinationally. Winner = data if data_req and not forced, else inst if inst_req. forced = inst_req && starve_cnt == STARVE_LIMIT (only with ARB_FAIRNESS_EN).
- Winner's *_addr_ok = 1 in IDLE only; the loser's addr_ok = 0. On the handshake (req && addr_ok), latch fields and own, then go to REQ.
- REQ: m_req = 1, m_* driven from hold registers. Stay in REQ until m_addr_ok = 1, then go to WAIT.
- WAIT: m_req = 0. On m_data_ok, pulse owner's *_data_ok for that same cycle and go to IDLE; *_rdata = m_rdata (both sides, unconditionally).
- m_data_ok in IDLE or REQ is ignored and not forwarded. Downstream must not return data_ok before addr_ok.
- Both *_addr_ok = 0 in REQ and WAIT, so there is at most one outstanding transaction.
- Starvation counter: on a data grant while inst_req = 1, increment, saturating at STARVE_LIMIT. Reset to 0 on an inst grant, or in any IDLE cycle with inst_req = 0.
- m_wdata is passed through untouched; byte strobes are the bridge's job.

## Timing
- Reset (asynchronous, resetn = 0): state = IDLE, own = 0, starve_cnt = 0, hold registers = 0, m_req = 0, both data_ok = 0. Addr_ok outputs are 0 whenever the requests are low.
- Accept at cycle T (IDLE). m_req = 1 from T+1. With m_addr_ok at T+1, enter WAIT at T+2. Earliest owner data_ok is T+2, combinational from m_data_ok.
- Back-to-back: data_ok at cycle D returns to IDLE at D+1, so the next addr_ok is at D+1 at the earliest. Minimum period is 3 cycles per transaction.
- Simultaneous inst_req and data_req in IDLE: data wins unless forced.
- Reset asserted in REQ or WAIT: the transaction is dropped; late downstream m_data_ok after reset is ignored (state IDLE).
- Upstream may drop *_req without an addr_ok; this has no effect on state.

## Configuration
- ARB_FAIRNESS_EN defined: starvation counter and forced-inst grant are present as described.
- Undefined: no counter is built; data_req always wins in IDLE. Inst can starve under continuous data traffic.

## Test plan
- Single inst read 0xBFC00000, m_addr_ok at T+1, m_data_ok at T+2 with m_rdata 0x3C080001 -> inst_addr_ok at T, m_req T+1, inst_data_ok and inst_rdata 0x3C080001 at T+2, data_data_ok stays 0.
- inst_req and data_req both high, data is a word write 0x80001000/0xDEADBEEF -> data granted first with m_wr = 1, m_wdata = 0xDEADBEEF. Inst is granted in the first IDLE after data_data_ok.
- m_addr_ok delayed 3 cycles in REQ -> m_req and m_addr/m_size held stable for all 4 cycles; no upstream addr_ok during that time.
- ARB_FAIRNESS_EN, STARVE_LIMIT = 8, data_req and inst_req held high -> exactly 8 data transactions, then 1 inst, then data again. Without the macro, inst is never granted.
- resetn pulled low in WAIT, then m_data_ok pulsed after release -> neither data_ok asserts; next request is accepted normally.
- Spurious m_data_ok in IDLE -> no *_data_ok, state unchanged.
